// File: rtl/dmem_pkg.sv
// Shared constants for the data-side memory subsystem: MMIO word offsets,
// STATUS bit positions, the default MMIO base and a byte-merge helper.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

    // MMIO register word offsets (d_addr[5:2])
    localparam logic [3:0] MTIME_LO_OFS    = 4'h0;
    localparam logic [3:0] MTIME_HI_OFS    = 4'h1;
    localparam logic [3:0] MTIMECMP_LO_OFS = 4'h2;
    localparam logic [3:0] MTIMECMP_HI_OFS = 4'h3;
    localparam logic [3:0] TXDATA_OFS      = 4'h4;
    localparam logic [3:0] STATUS_OFS      = 4'h5;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_CNT_LSB   = 4;
    localparam int STATUS_CNT_W     = 4;
    localparam int STATUS_IRQ_BIT   = 8;
    localparam int STATUS_OVF_BIT   = 9;

    // Replace the strobed byte lanes of old_word with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_word[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte TX FIFO with a valid/ready drain port. Full pushes are refused here;
// the caller decides whether that counts as an overflow.
module tx_fifo
    import dmem_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [Width-1:0]       push_data,
    output logic                   valid,
    input  logic                   ready,
    output logic [Width-1:0]       data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);
    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Handshake: a byte transfers on any edge where valid & ready are both 1;
    // data holds steady while valid is 1 and ready is 0. A push in a full
    // cycle is accepted only when a pop frees the slot on the same edge.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign valid   = ~empty;
    assign do_pop  = valid & ready;
    assign do_push = push & (~full | do_pop);
    assign data    = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory plus MMIO (64-bit timer with compare irq, byte TX FIFO).
// The timer is built only when DMEM_TIMER_EN is defined.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int          RamWords = 1024,
    parameter logic [31:0] MmioBase = MMIO_BASE_DEFAULT,
    parameter int          TxDepth  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);
    localparam int RAM_AW = $clog2(RamWords);
    localparam int CW     = $clog2(TxDepth) + 1;

    logic              is_mmio;
    logic [3:0]        ofs;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic [31:0]       ram [RamWords];
    logic [31:0]       mmio_rdata;
    logic [31:0]       timer_rdata;
    logic [31:0]       status;

    logic              push_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [STATUS_CNT_W-1:0] count_sat;
    logic              overflow;
    logic              ovf_set;
    logic              ovf_clr;

    assign is_mmio = (d_addr[31:28] == MmioBase[31:28]);
    assign ofs     = d_addr[5:2];
    assign ram_idx = d_addr[2 +: RAM_AW];
    assign ram_we  = ~is_mmio & (d_wstrb != 4'b0000);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{d_addr[1:0], d_addr[27:2+RAM_AW]};

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wstrb[b]) ram[ram_idx][8*b +: 8] <= d_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- TX FIFO and sticky overflow ----------------
    assign push_req = is_mmio & (ofs == TXDATA_OFS) & d_wstrb[0];
    assign ovf_set  = push_req & fifo_full & ~(tx_valid & tx_ready);
    assign ovf_clr  = is_mmio & (ofs == STATUS_OFS) & d_wstrb[1] & d_wdata[STATUS_OVF_BIT];

    tx_fifo #(.Width(8), .Depth(TxDepth)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (d_wdata[7:0]),
        .valid     (tx_valid),
        .ready     (tx_ready),
        .data      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    always_comb begin
        count_sat = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
    end

    // ---------------- Timer ----------------
`ifdef DMEM_TIMER_EN
    logic        reg_wr;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_inc;
    logic [63:0] mtime_d;
    logic [63:0] mtimecmp_d;

    assign reg_wr = is_mmio & (d_wstrb != 4'b0000);

    // Software writes override only the strobed bytes of the incremented value.
    always_comb begin
        mtime_inc   = mtime + 64'd1;
        mtime_d     = mtime_inc;
        mtimecmp_d  = mtimecmp;
        timer_rdata = '0;
        if (reg_wr) begin
            case (ofs)
                MTIME_LO_OFS:    mtime_d[31:0]     = merge_bytes(mtime_inc[31:0], d_wdata, d_wstrb);
                MTIME_HI_OFS:    mtime_d[63:32]    = merge_bytes(mtime_inc[63:32], d_wdata, d_wstrb);
                MTIMECMP_LO_OFS: mtimecmp_d[31:0]  = merge_bytes(mtimecmp[31:0], d_wdata, d_wstrb);
                MTIMECMP_HI_OFS: mtimecmp_d[63:32] = merge_bytes(mtimecmp[63:32], d_wdata, d_wstrb);
                default: ;
            endcase
        end
        case (ofs)
            MTIME_LO_OFS:    timer_rdata = mtime[31:0];
            MTIME_HI_OFS:    timer_rdata = mtime[63:32];
            MTIMECMP_LO_OFS: timer_rdata = mtimecmp[31:0];
            MTIMECMP_HI_OFS: timer_rdata = mtimecmp[63:32];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime    <= '0;
            mtimecmp <= '1;
        end else begin
            mtime    <= mtime_d;
            mtimecmp <= mtimecmp_d;
        end
    end

    assign timer_irq = (mtime >= mtimecmp);
`else
    assign timer_rdata = '0;
    assign timer_irq   = 1'b0;
`endif

    // ---------------- Read path ----------------
    always_comb begin
        status                                     = '0;
        status[STATUS_FULL_BIT]                    = fifo_full;
        status[STATUS_EMPTY_BIT]                   = fifo_empty;
        status[STATUS_CNT_LSB +: STATUS_CNT_W]     = count_sat;
        status[STATUS_IRQ_BIT]                     = timer_irq;
        status[STATUS_OVF_BIT]                     = overflow;
    end

    always_comb begin
        case (ofs)
            STATUS_OFS: mmio_rdata = status;
            TXDATA_OFS: mmio_rdata = '0;
            default:    mmio_rdata = timer_rdata;
        endcase
    end

    assign d_rdata = is_mmio ? mmio_rdata : ram[ram_idx];

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM strobes/alias, timer (when DMEM_TIMER_EN),
// TX FIFO fill/overflow/simultaneous push-pop, and async reset mid-drain.
module tb_dmem_mmio;
    import dmem_pkg::*;

    localparam logic [31:0] MB          = 32'h1000_0000;
    localparam logic [31:0] A_MTIME_LO  = MB + 32'h00;
    localparam logic [31:0] A_MTIME_HI  = MB + 32'h04;
    localparam logic [31:0] A_CMP_LO    = MB + 32'h08;
    localparam logic [31:0] A_CMP_HI    = MB + 32'h0C;
    localparam logic [31:0] A_TXDATA    = MB + 32'h10;
    localparam logic [31:0] A_STATUS    = MB + 32'h14;
    localparam logic [31:0] A_UNMAPPED  = MB + 32'h18;

    logic        clk;
    logic        reset;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    int total = 0;
    int bad   = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] rv;

    dmem_mmio #(.RamWords(1024), .MmioBase(32'h1000_0000), .TxDepth(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .timer_irq (timer_irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        d_addr  = addr;
        d_wdata = data;
        d_wstrb = strb;
        @(posedge clk);
        #1;
        d_wstrb = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        d_addr  = addr;
        d_wstrb = 4'b0000;
        #1;
        data = d_rdata;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b want=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h want=00", tx_data); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", timer_irq); end
        rd(A_STATUS, rv);
        total++; if (rv !== 32'h2) begin bad++; $display("FAIL rst_status got=%h want=00000002", rv); end
        rd(A_MTIME_LO, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst_mtime_lo got=%h want=0", rv); end
        rd(A_CMP_LO, rv);
`ifdef DMEM_TIMER_EN
        total++; if (rv !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_lo got=%h want=ffffffff", rv); end
`else
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst_cmp_lo got=%h want=0", rv); end
`endif
        rd(A_UNMAPPED, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst_unmapped got=%h want=0", rv); end
        rd(A_TXDATA, rv);
        total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst_txdata_rd got=%h want=0", rv); end
    endtask

    task automatic test_ram();
        wr(32'h100, 32'hAABB_CCDD, 4'hF);
        wr(32'h100, 32'h0000_1100, 4'b0010);
        rd(32'h100, rv);
        total++; if (rv !== 32'hAABB_11DD) begin bad++; $display("FAIL ram_strobe got=%h want=aabb11dd", rv); end
        rd(32'h100 + 32'd4096, rv);
        total++; if (rv !== 32'hAABB_11DD) begin bad++; $display("FAIL ram_alias got=%h want=aabb11dd", rv); end
        tick($urandom_range(1, 3));
        wr(32'h200, 32'h1111_2222, 4'hF);
        wr(32'h204, 32'h3333_4444, 4'hF);
        wr(32'h200, 32'hCD00_0000, 4'b1000);
        rd(32'h200, rv);
        total++; if (rv !== 32'hCD11_2222) begin bad++; $display("FAIL ram_lane3 got=%h want=cd112222", rv); end
        rd(32'h204, rv);
        total++; if (rv !== 32'h3333_4444) begin bad++; $display("FAIL ram_neighbour got=%h want=33334444", rv); end
    endtask

    task automatic test_timer();
`ifdef DMEM_TIMER_EN
        wr(A_CMP_HI, 32'd0, 4'hF);
        wr(A_CMP_LO, 32'd20, 4'hF);
        wr(A_MTIME_HI, 32'd0, 4'hF);
        wr(A_MTIME_LO, 32'd0, 4'hF);
        rd(A_MTIME_LO, rv);
        total++; if (rv !== 32'd0) begin bad++; $display("FAIL tmr_start got=%0d want=0", rv); end
        tick(19);
        rd(A_MTIME_LO, rv);
        total++; if (rv !== 32'd19) begin bad++; $display("FAIL tmr_at19 got=%0d want=19", rv); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL tmr_irq_early got=%b want=0", timer_irq); end
        tick(1);
        rd(A_MTIME_LO, rv);
        total++; if (rv !== 32'd20) begin bad++; $display("FAIL tmr_at20 got=%0d want=20", rv); end
        total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL tmr_irq_rise got=%b want=1", timer_irq); end
        rd(A_STATUS, rv);
        total++; if (rv !== 32'h102) begin bad++; $display("FAIL tmr_status_irq got=%h want=00000102", rv); end
        wr(A_CMP_LO, 32'hFFFF_FFFF, 4'hF);
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL tmr_irq_fall got=%b want=0", timer_irq); end
`else
        wr(A_MTIME_LO, 32'd1234, 4'hF);
        wr(A_CMP_LO, 32'd0, 4'hF);
        wr(A_CMP_HI, 32'd0, 4'hF);
        rd(A_MTIME_LO, rv);
        total++; if (rv !== 32'd0) begin bad++; $display("FAIL notmr_mtime got=%h want=0", rv); end
        rd(A_CMP_LO, rv);
        total++; if (rv !== 32'd0) begin bad++; $display("FAIL notmr_cmp got=%h want=0", rv); end
        tick(25);
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL notmr_irq got=%b want=0", timer_irq); end
        rd(A_STATUS, rv);
        total++; if (rv !== 32'h2) begin bad++; $display("FAIL notmr_status got=%h want=00000002", rv); end
`endif
    endtask

    task automatic test_timer_carry();
`ifdef DMEM_TIMER_EN
        wr(A_MTIME_HI, 32'd5, 4'hF);
        wr(A_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
        rd(A_MTIME_LO, rv);
        total++; if (rv !== 32'hFFFF_FFFF) begin bad++; $display("FAIL carry_pre_lo got=%h want=ffffffff", rv); end
        rd(A_MTIME_HI, rv);
        total++; if (rv !== 32'd5) begin bad++; $display("FAIL carry_pre_hi got=%h want=5", rv); end
        tick(1);
        rd(A_MTIME_LO, rv);
        total++; if (rv !== 32'd0) begin bad++; $display("FAIL carry_lo got=%h want=0", rv); end
        rd(A_MTIME_HI, rv);
        total++; if (rv !== 32'd6) begin bad++; $display("FAIL carry_hi got=%h want=6", rv); end
        // bring mtime back below the compare value before the FIFO tests
        wr(A_MTIME_HI, 32'd0, 4'hF);
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL carry_irq_clear got=%b want=0", timer_irq); end
`else
        wr(A_MTIME_HI, 32'd5, 4'hF);
        rd(A_MTIME_HI, rv);
        total++; if (rv !== 32'd0) begin bad++; $display("FAIL notmr_hi got=%h want=0", rv); end
`endif
    endtask

    task automatic test_fifo_fill();
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            wr(A_TXDATA, 32'(i), 4'b0001);
            if (i <= 8) exp_q.push_back(8'(i));
        end
        rd(A_STATUS, rv);
        total++; if (rv !== 32'h281) begin bad++; $display("FAIL fill_status got=%h want=00000281", rv); end
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin bad++; $display("FAIL fill_head got=%b/%h want=1/01", tx_valid, tx_data); end
        tick(3);
        total++; if (tx_data !== 8'h01) begin bad++; $display("FAIL fill_stable got=%h want=01", tx_data); end
        wr(A_STATUS, 32'h200, 4'b0010);
        rd(A_STATUS, rv);
        total++; if (rv !== 32'h81) begin bad++; $display("FAIL ovf_clear got=%h want=00000081", rv); end
    endtask

    task automatic test_fifo_simul();
        logic [7:0] head;
        total++; if (tx_data !== exp_q[0]) begin bad++; $display("FAIL simul_head got=%h want=%h", tx_data, exp_q[0]); end
        head = exp_q.pop_front();
        tx_ready = 1'b1;
        wr(A_TXDATA, 32'h55, 4'b0001);
        tx_ready = 1'b0;
        exp_q.push_back(8'h55);
        rd(A_STATUS, rv);
        total++; if (rv !== 32'h81) begin bad++; $display("FAIL simul_status got=%h want=00000081 (popped %h)", rv, head); end
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            tx_ready = 1'b1;
            #1;
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
                bad++;
                $display("FAIL drain_byte got=%b/%h want=1/%h", tx_valid, tx_data, exp_q[0]);
            end
            head = exp_q.pop_front();
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b0;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drain_timeout left=%0d want=0", exp_q.size()); end
        rd(A_STATUS, rv);
        total++; if (rv !== 32'h2 || tx_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%h/%b want=00000002/0", rv, tx_valid); end
    endtask

    task automatic test_fifo_empty_simul();
        tx_ready = 1'b1;
        wr(A_TXDATA, 32'hA5, 4'b0001);
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin bad++; $display("FAIL empty_simul got=%b/%h want=1/a5", tx_valid, tx_data); end
        rd(A_STATUS, rv);
        total++; if (rv !== 32'h10) begin bad++; $display("FAIL empty_simul_status got=%h want=00000010", rv); end
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL empty_simul_pop got=%b want=0", tx_valid); end
    endtask

    task automatic test_reset_mid_drain();
        tx_ready = 1'b0;
        wr(A_TXDATA, 32'h0A, 4'b0001);
        wr(A_TXDATA, 32'h0B, 4'b0001);
        wr(A_TXDATA, 32'h0C, 4'b0001);
        tx_ready = 1'b1;
        tick(1);
        #2;
        reset = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL midrst_fifo got=%b/%h want=0/00", tx_valid, tx_data); end
        rd(A_MTIME_LO, rv);
        total++; if (rv !== 32'd0) begin bad++; $display("FAIL midrst_mtime got=%h want=0", rv); end
        rd(A_STATUS, rv);
        total++; if (rv !== 32'h2) begin bad++; $display("FAIL midrst_status got=%h want=00000002", rv); end
        tx_ready = 1'b0;
        reset    = 1'b1;
        tick(1);
        rd(32'h100, rv);
        total++; if (rv !== 32'hAABB_11DD) begin bad++; $display("FAIL midrst_ram got=%h want=aabb11dd", rv); end
        wr(A_TXDATA, 32'h77, 4'b0001);
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin bad++; $display("FAIL midrst_push got=%b/%h want=1/77", tx_valid, tx_data); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset    = 1'b0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        d_wstrb  = 4'b0000;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        tick(1);
        test_ram();
        tick($urandom_range(1, 4));
        test_timer();
        test_timer_carry();
        test_fifo_fill();
        test_fifo_simul();
        tick($urandom_range(1, 4));
        test_fifo_empty_simul();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
